// File: rtl/pio_out_blink.sv
// pio_out_blink: Avalon-MM output PIO for LEDs with atomic set/clear,
// per-bit hardware blink driven by a programmable half-period prescaler,
// and a phase status readback. Zero-wait-state slave, readdata is
// combinational from address.
// Optional macro PIO_OUT_BLINK_ACTIVE_LOW_EN inverts out_port for
// active-low LEDs; register readback is unaffected.
module pio_out_blink #(
    parameter int unsigned WIDTH          = 5,
    parameter int unsigned PRESCALE_W     = 26,
    parameter logic [31:0] RESET_VALUE    = 32'h0,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd24999999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_BLINK  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_SET    = 3'd3;
    localparam logic [2:0] ADDR_CLR    = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    localparam logic [WIDTH-1:0]      RST_DATA = RESET_VALUE[WIDTH-1:0];
    localparam logic [PRESCALE_W-1:0] RST_PER  = DEFAULT_PERIOD[PRESCALE_W-1:0];
    localparam logic [PRESCALE_W-1:0] CNT_ONE  = PRESCALE_W'(1);

    logic [WIDTH-1:0]      r_data;
    logic [WIDTH-1:0]      r_blink_en;
    logic [PRESCALE_W-1:0] r_period;
    logic [PRESCALE_W-1:0] r_cnt;
    logic                  r_phase;

    logic                  w_wr;
    logic                  w_period_wr;
    logic [WIDTH-1:0]      w_wd;
    logic [PRESCALE_W-1:0] w_wp;
    logic [WIDTH-1:0]      w_led;
    logic                  w_unused;

    assign w_wr        = chipselect & ~write_n;
    assign w_period_wr = w_wr && (address == ADDR_PERIOD);
    assign w_wd        = writedata[WIDTH-1:0];
    assign w_wp        = writedata[PRESCALE_W-1:0];
    // Upper writedata bits are ignored for narrow fields.
    assign w_unused    = &{1'b0, writedata};

    // Register file writes; OUTSET/OUTCLEAR are read-modify-write of DATA in one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data     <= RST_DATA;
            r_blink_en <= '0;
            r_period   <= RST_PER;
        end else if (w_wr) begin
            case (address)
                ADDR_DATA:   r_data     <= w_wd;
                ADDR_BLINK:  r_blink_en <= w_wd;
                ADDR_PERIOD: r_period   <= w_wp;
                ADDR_SET:    r_data     <= r_data | w_wd;
                ADDR_CLR:    r_data     <= r_data & ~w_wd;
                default:     ;
            endcase
        end
    end

    // Free-running half-period prescaler; a period write restarts it high so a
    // shorter period can never be overrun by a counter already past it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (w_period_wr) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (r_cnt == r_period) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + CNT_ONE;
        end
    end

    // LED drive from registers only; blinking bits are gated by phase.
    always_comb begin
        w_led = (r_data & ~r_blink_en) | (r_data & r_blink_en & {WIDTH{r_phase}});
    end

`ifdef PIO_OUT_BLINK_ACTIVE_LOW_EN
    assign out_port = ~w_led;
`else
    assign out_port = w_led;
`endif

    // Read mux; write-only and reserved words read as zero.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[WIDTH-1:0]      = r_data;
            ADDR_BLINK:  readdata[WIDTH-1:0]      = r_blink_en;
            ADDR_PERIOD: readdata[PRESCALE_W-1:0] = r_period;
            ADDR_STATUS: readdata[0]              = r_phase;
            default:     ;
        endcase
    end

endmodule

// File: tb/tb_pio_out_blink.sv
// Bench for pio_out_blink: directed literal checks plus randomized traffic
// checked every cycle against a time-based behavioural model.
module tb_pio_out_blink;
    localparam int          W  = 5;
    localparam int          PW = 26;
    localparam logic [31:0] RV = 32'h0000000A;
    localparam logic [31:0] DP = 32'd24999999;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cs = 1'b0;
    logic          write_n = 1'b1;
    logic [2:0]    address = 3'd0;
    logic [31:0]   writedata = 32'd0;
    logic [31:0]   readdata;
    logic [W-1:0]  out_port;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pio_out_blink #(
        .WIDTH(W), .PRESCALE_W(PW), .RESET_VALUE(RV), .DEFAULT_PERIOD(DP)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port)
    );

    // Model: phase derived from elapsed cycles since the last prescaler restart.
    logic [W-1:0] m_data;
    logic [W-1:0] m_en;
    longint       m_per;
    longint       m_t;
    bit           m_ok = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_data = RV[W-1:0];
            m_en   = '0;
            m_per  = longint'(DP[PW-1:0]);
            m_t    = 0;
            m_ok   = 1'b1;
        end else if (m_ok) begin
            if (cs && !write_n && address == 3'd2) begin
                m_per = longint'(writedata[PW-1:0]);
                m_t   = 0;
            end else begin
                m_t = m_t + 1;
                if (cs && !write_n) begin
                    case (address)
                        3'd0: m_data = writedata[W-1:0];
                        3'd1: m_en   = writedata[W-1:0];
                        3'd3: m_data = m_data | writedata[W-1:0];
                        3'd4: m_data = m_data & ~writedata[W-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    function automatic bit m_phase();
        return ((m_t / (m_per + 1)) % 2) == 0;
    endfunction

    function automatic logic [W-1:0] led(input logic [W-1:0] x);
`ifdef PIO_OUT_BLINK_ACTIVE_LOW_EN
        return ~x;
`else
        return x;
`endif
    endfunction

    function automatic logic [W-1:0] m_led();
        logic [W-1:0] on;
        on = m_data & (~m_en | {W{m_phase()}});
        return led(on);
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            3'd0: r[W-1:0] = m_data;
            3'd1: r[W-1:0] = m_en;
            3'd2: r = 32'(m_per);
            3'd5: r[0] = m_phase();
            default: ;
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous compare against the model once reset has been seen.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("model_out_port", 32'(out_port), 32'(m_led()));
            chk("model_readdata", readdata, m_rd(address));
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cs = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk); #1;
        cs = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        @(negedge clk);
        chk(name, readdata, exp);
        @(posedge clk); #1;
    endtask

    task automatic chk_out(input string name, input logic [W-1:0] exp);
        @(negedge clk);
        chk(name, 32'(out_port), 32'(led(exp)));
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Reset state
        chk_out("rst_out", 5'h0A);
        rd("rst_data", 3'd0, 32'h0000000A);
        rd("rst_blink", 3'd1, 32'h0);
        rd("rst_period", 3'd2, DP);
        rd("rst_status", 3'd5, 32'h1);

        // Plain write, set, clear
        wr(3'd0, 32'hFFFFFFE5);
        chk_out("wr_data_out", 5'h05);
        rd("wr_data_rd", 3'd0, 32'h00000005);
        wr(3'd3, 32'h0000000A);
        chk_out("outset", 5'h0F);
        wr(3'd4, 32'h00000003);
        chk_out("outclear", 5'h0C);
        rd("rd_set", 3'd3, 32'h0);
        rd("rd_clr", 3'd4, 32'h0);

        // Blink half-period 4 cycles on bit 2
        wr(3'd1, 32'h04);
        wr(3'd0, 32'h05);
        wr(3'd2, 32'd3);
        address = 3'd5;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("blink3_out", 32'(out_port), 32'(led((i < 4) ? 5'h05 : 5'h01)));
            chk("blink3_status", readdata, (i < 4) ? 32'h1 : 32'h0);
        end
        @(posedge clk); #1;

        // Period 0: toggle every cycle, then restart with period 7
        wr(3'd1, 32'h1F);
        wr(3'd0, 32'h1F);
        wr(3'd2, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("blink0_out", 32'(out_port), 32'(led((i % 2 == 0) ? 5'h1F : 5'h00)));
        end
        @(posedge clk); #1;
        wr(3'd2, 32'd7);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("blink7_out", 32'(out_port), 32'(led((i < 8) ? 5'h1F : 5'h00)));
        end
        @(posedge clk); #1;

        // Reset wins over a simultaneous write
        reset = 1'b1; cs = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 32'h15;
        @(posedge clk); #1;
        reset = 1'b0; cs = 1'b0; write_n = 1'b1;
        chk_out("rst2_out", 5'h0A);
        rd("rst2_data", 3'd0, 32'h0000000A);
        rd("rst2_blink", 3'd1, 32'h0);
        rd("rst2_period", 3'd2, DP);
        rd("rst2_status", 3'd5, 32'h1);

        // Static drive (inverted pins when built active-low)
        wr(3'd0, 32'h03);
        chk_out("static_out", 5'h03);
        rd("static_rd", 3'd0, 32'h00000003);

        // Randomized traffic, checked by the model process
        repeat (3000) begin
            reset   = ($urandom_range(0, 99) == 0);
            cs      = $urandom_range(0, 1);
            write_n = $urandom_range(0, 1);
            address = 3'($urandom_range(0, 7));
            writedata = (address == 3'd2) ? 32'($urandom_range(0, 12)) : $urandom;
            @(posedge clk); #1;
        end
        reset = 1'b0; cs = 1'b0; write_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
